axi_stream_packet_arbiter: RTL and testbench
============================================

# axi_stream_packet_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream master port between NUM_SRC AXI-Stream slave sources. A grant is held for a whole packet (until the beat carrying last) so packets are never interleaved. It sits in front of the stream datapath (e.g. the axi_stream_interface_top input) and is the single point that decides which requester owns it.

## Interface
- NUM_SRC, 4: number of slave sources, legal range 2..8.
- DATA_WIDTH, 32: data width of every stream.
- GW, $clog2(NUM_SRC): grant index width (derived, not overridden).
- s_axis_clk  in  1  single clock for all logic.
- s_axis_resetn  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to s_axis_clk.
- s_axis_valid  in  NUM_SRC  per-source valid, bit i = source i.
- s_axis_last  in  NUM_SRC  per-source end-of-packet.
- s_axis_data  in  NUM_SRC*DATA_WIDTH  source i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_ready  out  NUM_SRC  per-source ready.
- m_axis_valid  out  1  merged stream valid.
- m_axis_last  out  1  merged stream last.
- m_axis_data  out  DATA_WIDTH  merged stream data.
- m_axis_ready  in  1  downstream ready.
- grant_id  out  GW  index of the current/most recent granted source.
- busy  out  1  high while in PASS.
- pkt_count  out  16  number of completed packets forwarded, wraps at 65535 -> 0.

## Operation
- FSM with two states: IDLE and PASS.
- Registered state: state, grant_id, last_grant (GW bits), pkt_count.
- Reset values: state=IDLE, grant_id=0, last_grant=NUM_SRC-1 (so source 0 wins first), pkt_count=0, busy=0.
- IDLE: all s_axis_ready=0, m_axis_valid=0, m_axis_last=0, m_axis_data=0. If any s_axis_valid bit is set, choose the first set bit searching last_grant+1, last_grant+2, ... modulo NUM_SRC; register it into grant_id; next state PASS.
- PASS, with g=grant_id: m_axis_valid=s_axis_valid[g], m_axis_last=s_axis_last[g], m_axis_data=source g data (combinational mux); s_axis_ready[g]=m_axis_ready, all other ready bits 0.
- A beat transfers when m_axis_valid & m_axis_ready. A transferred beat with m_axis_last=1: next state IDLE, last_grant<=g, pkt_count<=pkt_count+1 (16-bit wrap).
- Valid drop by the granted source mid-packet: remain in PASS, output valid follows it, no re-arbitration.
- Requests from non-granted sources are ignored until the return to IDLE; they must hold valid per AXI-Stream rules and are never dropped.
- Single-beat packet (valid & last on first beat): one transfer, then back to IDLE.
- Reset asserted mid-packet: immediate return to reset values; the partial packet is truncated downstream and is not repaired.
- NUM_SRC not a power of two: the round-robin wrap uses modulo NUM_SRC; indices >= NUM_SRC are never granted.

## Timing
- Arbitration latency: request in IDLE at cycle N -> grant registered at edge N+1 -> first beat can transfer in cycle N+1.
- Exactly one IDLE cycle separates consecutive packets. Peak throughput is L/(L+1) for L-beat packets.
- Inside PASS the data path is combinational, with zero added latency; ready/valid are passed straight through.
- grant_id is stable for the whole of PASS and holds its value through IDLE until the next grant.
- busy = (state==PASS) is registered-state decoded, with no combinational path from inputs.
- pkt_count updates on the edge after the last beat.

## Test plan
- Reset release with only source 2 valid, sending 3 beats 0xA0,0xA1,0xA2 (last on 0xA2), m_axis_ready=1 -> grant_id=2 one cycle later; output beats 0xA0..0xA2 in 3 consecutive cycles; pkt_count=1; busy returns to 0.
- All 4 sources continuously valid with 2-beat packets -> grant order 0,1,2,3,0; one IDLE cycle between packets; no beat of a source appears inside another source's packet.
- Downstream backpressure: m_axis_ready toggles 1,0,1,0 during a 4-beat packet from source 1 -> only s_axis_ready[1] follows m_axis_ready; the data sequence is intact; other ready bits stay 0.
- Granted source deasserts valid for 3 cycles mid-packet while source 0 is requesting -> no re-grant; grant_id unchanged until last transfers; then source 0 is served.
- Assert s_axis_resetn=0 asynchronously mid-packet -> m_axis_valid=0, all s_axis_ready=0, and busy=0 immediately; pkt_count=0; after release the first grant goes to source 0 when all sources request.
- Preload pkt_count via 65535 single-beat packets (or force), then send one more -> pkt_count wraps to 0.

Source files
------------

// File: rtl/axi_stream_packet_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-Stream sources onto one
// master port. A grant is held from the first beat until the beat carrying
// last, so packets from different sources are never interleaved.
// s_axis_resetn is expected to be released synchronously to s_axis_clk.
module axi_stream_packet_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned GW        = $clog2(NUM_SRC)
) (
  input  logic                          s_axis_clk,
  input  logic                          s_axis_resetn,
  input  logic [NUM_SRC-1:0]            s_axis_valid,
  input  logic [NUM_SRC-1:0]            s_axis_last,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_data,
  output logic [NUM_SRC-1:0]            s_axis_ready,
  output logic                          m_axis_valid,
  output logic                          m_axis_last,
  output logic [DATA_WIDTH-1:0]         m_axis_data,
  input  logic                          m_axis_ready,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic [15:0]                   pkt_count
);

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [GW-1:0]           grant_next;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           last_grant_next;
  logic [15:0]             pkt_count_next;
  logic                    rr_found;
  logic [GW-1:0]           rr_pick;
  logic [GW-1:0]           rr_cand;
  logic [DATA_WIDTH-1:0]   src_data [NUM_SRC];

  // Unpack the flat source data bus into one word per source.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_data[i] = s_axis_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting just after the previous winner, wrapping modulo NUM_SRC.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_cand  = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      rr_cand = GW'((32'(last_grant) + i) % NUM_SRC);
      if (!rr_found && s_axis_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  // Next-state and stream steering: closed in IDLE, straight pass-through of the granted source in PASS.
  always_comb begin
    state_next      = state;
    grant_next      = grant_id;
    last_grant_next = last_grant;
    pkt_count_next  = pkt_count;
    s_axis_ready    = '0;
    m_axis_valid    = 1'b0;
    m_axis_last     = 1'b0;
    m_axis_data     = '0;
    case (state)
      IDLE: begin
        if (rr_found) begin
          grant_next = rr_pick;
          state_next = PASS;
        end
      end
      PASS: begin
        m_axis_valid           = s_axis_valid[grant_id];
        m_axis_last            = s_axis_last[grant_id];
        m_axis_data            = src_data[grant_id];
        s_axis_ready[grant_id] = m_axis_ready;
        if (s_axis_valid[grant_id] && m_axis_ready && s_axis_last[grant_id]) begin
          state_next      = IDLE;
          last_grant_next = grant_id;
          pkt_count_next  = pkt_count + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, grant and packet counter registers; last_grant resets so source 0 wins first.
  always_ff @(posedge s_axis_clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_SRC - 1);
      pkt_count  <= '0;
    end else begin
      state      <= state_next;
      grant_id   <= grant_next;
      last_grant <= last_grant_next;
      pkt_count  <= pkt_count_next;
    end
  end

  assign busy = (state == PASS);

endmodule

// File: tb/tb_axi_stream_packet_arbiter.sv
// Directed bench for axi_stream_packet_arbiter (NUM_SRC=4, DATA_WIDTH=32).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_axi_stream_packet_arbiter;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned DW      = 32;
  localparam int unsigned GW      = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_SRC-1:0]    valid;
  logic [NUM_SRC-1:0]    last;
  logic [DW-1:0]         sd [NUM_SRC];
  logic [NUM_SRC*DW-1:0] data_bus;
  logic [NUM_SRC-1:0]    s_ready;
  logic                  m_valid;
  logic                  m_last;
  logic [DW-1:0]         m_data;
  logic                  m_ready;
  logic [GW-1:0]         grant_id;
  logic                  busy;
  logic [15:0]           pkt_count;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  axi_stream_packet_arbiter #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DW)) dut (
    .s_axis_clk    (clk),
    .s_axis_resetn (rst_n),
    .s_axis_valid  (valid),
    .s_axis_last   (last),
    .s_axis_data   (data_bus),
    .s_axis_ready  (s_ready),
    .m_axis_valid  (m_valid),
    .m_axis_last   (m_last),
    .m_axis_data   (m_data),
    .m_axis_ready  (m_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  always_comb data_bus = {sd[3], sd[2], sd[1], sd[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = '0;
    last  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] acc;
    int beat [NUM_SRC];
    int ph, pkt, src, b;

    rst_n   = 1'b0;
    valid   = '0;
    last    = '0;
    m_ready = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) sd[i] = '0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt", 32'(pkt_count), 32'd0);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_sready", 32'(s_ready), 32'd0);

    // T1: only source 2, three beats A0..A2
    @(negedge clk);
    rst_n = 1'b1;
    valid = 4'b0100;
    sd[2] = 32'hA0;
    #1;
    chk("t1_idle_mvalid", 32'(m_valid), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    chk("t1_grant", 32'(grant_id), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_b0", m_data, 32'hA0);
    chk("t1_sready", 32'(s_ready), 32'h4);
    @(negedge clk);
    sd[2] = 32'hA1;
    #1;
    chk("t1_b1", m_data, 32'hA1);
    chk("t1_b1_last", 32'(m_last), 32'd0);
    @(negedge clk);
    sd[2] = 32'hA2;
    last  = 4'b0100;
    #1;
    chk("t1_b2", m_data, 32'hA2);
    chk("t1_b2_last", 32'(m_last), 32'd1);
    @(negedge clk);
    valid = '0;
    last  = '0;
    #1;
    chk("t1_pkt", 32'(pkt_count), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_grant_hold", 32'(grant_id), 32'd2);
    chk("t1_mvalid_end", 32'(m_valid), 32'd0);

    // T2: all sources valid, 2-beat packets, grants 0,1,2,3,0 with one IDLE gap
    do_reset();
    acc = '0;
    for (int i = 0; i < NUM_SRC; i++) beat[i] = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_SRC; i++) begin
        beat[i] += int'(acc[i]);
        sd[i]    = 32'(i * 256 + beat[i]);
        last[i]  = (beat[i] % 2 == 1);
      end
      valid = 4'hF;
      #1;
      ph  = k % 3;
      pkt = k / 3;
      src = pkt % 4;
      b   = 2 * (pkt / 4) + ph - 1;
      if (ph == 0) begin
        chk("t2_gap_mvalid", 32'(m_valid), 32'd0);
        chk("t2_gap_busy", 32'(busy), 32'd0);
        chk("t2_gap_sready", 32'(s_ready), 32'd0);
      end else begin
        chk("t2_grant", 32'(grant_id), 32'(src));
        chk("t2_mvalid", 32'(m_valid), 32'd1);
        chk("t2_data", m_data, 32'(src * 256 + b));
        chk("t2_last", 32'(m_last), 32'(ph == 2));
        chk("t2_sready", 32'(s_ready), 32'(1 << src));
      end
      acc = s_ready & valid;
    end
    @(negedge clk);
    valid = '0;
    last  = '0;
    #1;
    chk("t2_pkt", 32'(pkt_count), 32'd5);
    chk("t2_busy_end", 32'(busy), 32'd0);
    chk("t2_grant_hold", 32'(grant_id), 32'd0);

    // T3: backpressure on a 4-beat packet from source 1
    @(negedge clk);
    valid = 4'b0010;
    sd[1] = 32'hB0;
    #1;
    chk("t3_idle_sready", 32'(s_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("t3_grant", 32'(grant_id), 32'd1);
    chk("t3_d0", m_data, 32'hB0);
    chk("t3_rdy0", 32'(s_ready), 32'h2);
    @(negedge clk);
    sd[1]   = 32'hB1;
    m_ready = 1'b0;
    #1;
    chk("t3_stall1_rdy", 32'(s_ready), 32'd0);
    chk("t3_stall1_valid", 32'(m_valid), 32'd1);
    chk("t3_stall1_data", m_data, 32'hB1);
    chk("t3_stall1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    chk("t3_rdy1", 32'(s_ready), 32'h2);
    chk("t3_d1", m_data, 32'hB1);
    @(negedge clk);
    sd[1]   = 32'hB2;
    m_ready = 1'b0;
    #1;
    chk("t3_stall2_rdy", 32'(s_ready), 32'd0);
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    chk("t3_d2", m_data, 32'hB2);
    chk("t3_rdy2", 32'(s_ready), 32'h2);
    @(negedge clk);
    sd[1]   = 32'hB3;
    last    = 4'b0010;
    m_ready = 1'b0;
    #1;
    chk("t3_stall3_rdy", 32'(s_ready), 32'd0);
    chk("t3_stall3_last", 32'(m_last), 32'd1);
    @(negedge clk);
    m_ready = 1'b1;
    #1;
    chk("t3_d3", m_data, 32'hB3);
    chk("t3_rdy3", 32'(s_ready), 32'h2);
    @(negedge clk);
    valid = '0;
    last  = '0;
    #1;
    chk("t3_pkt", 32'(pkt_count), 32'd6);
    chk("t3_busy_end", 32'(busy), 32'd0);

    // T4: granted source 3 drops valid for 3 cycles while source 0 waits
    @(negedge clk);
    valid = 4'b1001;
    last  = 4'b0001;
    sd[3] = 32'hC0;
    sd[0] = 32'hD0;
    @(negedge clk);
    #1;
    chk("t4_grant", 32'(grant_id), 32'd3);
    chk("t4_c0", m_data, 32'hC0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      valid = 4'b0001;
      #1;
      chk("t4_gap_mvalid", 32'(m_valid), 32'd0);
      chk("t4_gap_grant", 32'(grant_id), 32'd3);
      chk("t4_gap_busy", 32'(busy), 32'd1);
      chk("t4_gap_sready", 32'(s_ready), 32'h8);
    end
    @(negedge clk);
    valid = 4'b1001;
    last  = 4'b1001;
    sd[3] = 32'hC1;
    #1;
    chk("t4_c1", m_data, 32'hC1);
    chk("t4_c1_last", 32'(m_last), 32'd1);
    chk("t4_c1_grant", 32'(grant_id), 32'd3);
    @(negedge clk);
    valid = 4'b0001;
    last  = 4'b0001;
    #1;
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_idle_pkt", 32'(pkt_count), 32'd7);
    @(negedge clk);
    #1;
    chk("t4_src0_grant", 32'(grant_id), 32'd0);
    chk("t4_src0_data", m_data, 32'hD0);
    @(negedge clk);
    valid = '0;
    last  = '0;
    #1;
    chk("t4_pkt", 32'(pkt_count), 32'd8);

    // T5: asynchronous reset in the middle of a packet from source 2
    @(negedge clk);
    valid = 4'b0100;
    sd[2] = 32'hE0;
    @(negedge clk);
    #1;
    chk("t5_grant", 32'(grant_id), 32'd2);
    @(negedge clk);
    sd[2] = 32'hE1;
    #1;
    chk("t5_busy_pre", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_mvalid", 32'(m_valid), 32'd0);
    chk("t5_rst_sready", 32'(s_ready), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_pkt", 32'(pkt_count), 32'd0);
    chk("t5_rst_grant", 32'(grant_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 4'hF;
    for (int i = 0; i < NUM_SRC; i++) sd[i] = 32'(32'hF0 + i);
    #1;
    chk("t5_rel_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #1;
    chk("t5_first_grant", 32'(grant_id), 32'd0);
    chk("t5_first_data", m_data, 32'hF0);
    @(negedge clk);
    valid = 4'b0001;
    last  = 4'b0001;
    sd[0] = 32'hF5;
    #1;
    chk("t5_last_data", m_data, 32'hF5);
    @(negedge clk);
    valid = '0;
    last  = '0;
    #1;
    chk("t5_pkt", 32'(pkt_count), 32'd1);

    // T6: packet counter wrap from 65535 to 0
    @(negedge clk);
    force dut.pkt_count = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_count;
    #1;
    chk("t6_preload", 32'(pkt_count), 32'hFFFF);
    @(negedge clk);
    valid = 4'b0010;
    last  = 4'b0010;
    sd[1] = 32'h55;
    @(negedge clk);
    #1;
    chk("t6_grant", 32'(grant_id), 32'd1);
    chk("t6_data", m_data, 32'h55);
    @(negedge clk);
    valid = '0;
    last  = '0;
    #1;
    chk("t6_wrap", 32'(pkt_count), 32'd0);
    chk("t6_busy_end", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
